// File: rtl/kernel_tap_reader.sv
// kernel_tap_reader
// -----------------
// Initiator side of the kernel coefficient memory. On an accepted start it
// latches a TAPS-pixel window, walks the coefficient memory through
// addresses 0..TAPS-1, multiplies each returned coefficient by the matching
// latched pixel, and accumulates the products. At the end it emits the raw
// sum plus a normalised, saturated 8-bit pixel with a one-cycle valid pulse.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start          evaluation request, sampled only in IDLE
//   window         TAPS pixels, pixel k = window[8k+7:8k]
//   mem_address    registered coefficient address
//   mem_read_data  coefficient, returned one clock after its address
//   busy           evaluation in progress
//   acc_out        raw 16-bit weighted sum (held until the next result)
//   pix_out        min(acc_out >> NORM_SHIFT, 255) (held likewise)
//   result_valid   one-cycle pulse marking a new acc_out/pix_out
//   dbg_state_o    current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Handshake: start has no ready. It is accepted on any edge where the FSM
// is IDLE (busy low), including the result_valid cycle; a start seen while
// busy is dropped, never queued. result_valid has no back-pressure.

module kernel_tap_reader #(
  parameter int TAPS       = 7,
  parameter int NORM_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8*TAPS-1:0] window,
  output logic [2:0]        mem_address,
  input  logic [7:0]        mem_read_data,
  output logic              busy,
  output logic [15:0]       acc_out,
  output logic [7:0]        pix_out,
  output logic              result_valid,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ADDR = 3'(TAPS - 1);

  state_t            state_q, state_d;
  logic [2:0]        addr_q, addr_d;
  logic [8*TAPS-1:0] win_q, win_d;
  logic [15:0]       acc_q, acc_d;
  // tap_vld_q marks that mem_read_data currently carries the coefficient
  // for address tap_idx_q; it trails the issued address by one edge.
  logic              tap_vld_q, tap_vld_d;
  logic [2:0]        tap_idx_q, tap_idx_d;
  logic              busy_q, busy_d;
  logic [15:0]       acc_out_q, acc_out_d;
  logic [7:0]        pix_out_q, pix_out_d;
  logic              rv_q, rv_d;

  logic [7:0]        tap_pix;
  logic [15:0]       product;
  logic [15:0]       acc_sum;
  logic [15:0]       acc_shifted;
  logic              last_tap;

  // ---------------------------------------------------------------------
  // Process 1: state and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 3'd0;
      win_q     <= '0;
      acc_q     <= 16'd0;
      tap_vld_q <= 1'b0;
      tap_idx_q <= 3'd0;
      busy_q    <= 1'b0;
      acc_out_q <= 16'd0;
      pix_out_q <= 8'd0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      tap_vld_q <= tap_vld_d;
      tap_idx_q <= tap_idx_d;
      busy_q    <= busy_d;
      acc_out_q <= acc_out_d;
      pix_out_q <= pix_out_d;
      rv_q      <= rv_d;
    end
  end

  // Final tap is on the memory data bus this cycle: the closing edge.
  assign last_tap = tap_vld_q && (tap_idx_q == LAST_ADDR);

  // ---------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      // Leave ISSUE on the edge that drives the last address.
      S_ISSUE: if (addr_q == LAST_ADDR - 3'd1) state_d = S_DRAIN;
      S_DRAIN: if (last_tap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel matching the coefficient currently on mem_read_data.
  always_comb begin
    tap_pix = 8'd0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_idx_q == 3'(k)) tap_pix = win_q[8*k +: 8];
    end
  end

  assign product     = {8'd0, tap_pix} * {8'd0, mem_read_data};
  assign acc_sum     = acc_q + product;  // wraps modulo 2^16 by design
  assign acc_shifted = acc_sum >> NORM_SHIFT;

  // ---------------------------------------------------------------------
  // Process 3: output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    addr_d    = addr_q;
    win_d     = win_q;
    acc_d     = acc_q;
    tap_vld_d = 1'b0;
    tap_idx_d = addr_q;
    busy_d    = busy_q;
    acc_out_d = acc_out_q;
    pix_out_d = pix_out_q;
    rv_d      = 1'b0;

    if (tap_vld_q) acc_d = acc_sum;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d  = window;
          acc_d  = 16'd0;
          addr_d = 3'd0;
          busy_d = 1'b1;
        end
      end
      S_ISSUE: begin
        tap_vld_d = 1'b1;
        addr_d    = addr_q + 3'd1;
      end
      S_DRAIN: begin
        // The last address was issued on the edge entering DRAIN, so one
        // more valid tap follows unless this edge is consuming it.
        if (last_tap) begin
          acc_out_d = acc_sum;
          pix_out_d = (acc_shifted > 16'd255) ? 8'hFF : acc_shifted[7:0];
          rv_d      = 1'b1;
          busy_d    = 1'b0;
          addr_d    = 3'd0;
        end else begin
          tap_vld_d = 1'b1;
        end
      end
      default: begin
        addr_d = 3'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign mem_address  = addr_q;
  assign busy         = busy_q;
  assign acc_out      = acc_out_q;
  assign pix_out      = pix_out_q;
  assign result_valid = rv_q;
  assign dbg_state_o  = state_q;

endmodule
